t5_wbarb: RTL and testbench

T5_WBARB -- requirements
Module: t5_wbarb

---
 rtl/t5_pkg.sv | 23 ++
 rtl/t5_wbarb_tmo.sv | 38 +++
 rtl/t5_wbarb.sv | 169 ++++++++++++++++
 tb/tb_t5_wbarb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// Shared types and constants for the t5 Wishbone two-master arbiter.
// The FSM state encoding doubles as the gnt output encoding.
package t5_pkg;

    localparam int unsigned TMO_DEFAULT = 255;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned ADR_W       = 30;
    localparam int unsigned SEL_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IBUS = 2'b01,
        DBUS = 2'b10
    } state_e;

    // Request payload shared by both masters and the slave port (data kept separate, width is XLEN)
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic             wre;
        logic [SEL_W-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/t5_wbarb_tmo.sv
// Wait counter for the granted master: counts granted cycles without ack and
// flags expiry on the TMO-th such cycle (expired is combinational from the count).
module t5_wbarb_tmo
    import t5_pkg::*;
#(
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the ack-less cycles already spent, so the current cycle is number cnt_q+1
    assign expired = (cnt_q == CNT_W'(TMO - 1));

endmodule

// File: rtl/t5_wbarb.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with wait timeout.
// Define T5_WBARB_RR_EN for round-robin on simultaneous requests; default is data-first.
module t5_wbarb
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = TMO_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [31:2]     iwb_adr,
    input  logic            iwb_stb,
    input  logic            iwb_wre,
    input  logic [3:0]      iwb_sel,
    output logic [XLEN-1:0] iwb_dat,
    output logic            iwb_ack,
    input  logic [31:2]     dwb_adr,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    input  logic [3:0]      dwb_sel,
    input  logic [XLEN-1:0] dwb_dto,
    output logic [XLEN-1:0] dwb_dti,
    output logic            dwb_ack,
    output logic [31:2]     mwb_adr,
    output logic            mwb_stb,
    output logic            mwb_wre,
    output logic [3:0]      mwb_sel,
    output logic [XLEN-1:0] mwb_dto,
    input  logic [XLEN-1:0] mwb_dti,
    input  logic            mwb_ack,
    output logic [1:0]      gnt,
    output logic            tmo_err
);

    state_e  state_q;
    state_e  state_d;
    logic    own_stb;
    logic    ack_c;
    logic    tmo_hit;
    logic    pick_d;
    logic    cnt_clr;
    logic    cnt_inc;
    logic    expired;
    wb_req_t req_m;

    // Strobe of whichever master currently holds the grant
    always_comb begin
        own_stb = 1'b0;
        case (state_q)
            IBUS:    own_stb = iwb_stb;
            DBUS:    own_stb = dwb_stb;
            default: own_stb = 1'b0;
        endcase
    end

    assign ack_c   = own_stb & mwb_ack;
    assign tmo_hit = own_stb & expired & ~mwb_ack;

`ifdef T5_WBARB_RR_EN
    logic last_q;
    logic last_d;

    // last_q: 1 = data master granted most recently, 0 = instruction master
    always_comb begin
        last_d = last_q;
        if ((state_d != state_q) && (state_d != IDLE)) begin
            last_d = (state_d == DBUS);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick_d = ~last_q;
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort on dropped strobe, hand over on ack, give up on timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iwb_stb && dwb_stb) begin
                    state_d = pick_d ? DBUS : IBUS;
                end else if (dwb_stb) begin
                    state_d = DBUS;
                end else if (iwb_stb) begin
                    state_d = IBUS;
                end
            end
            IBUS: begin
                if (!iwb_stb || tmo_hit) begin
                    state_d = IDLE;
                end else if (mwb_ack) begin
                    state_d = dwb_stb ? DBUS : IDLE;
                end
            end
            DBUS: begin
                if (!dwb_stb || tmo_hit) begin
                    state_d = IDLE;
                end else if (mwb_ack) begin
                    state_d = iwb_stb ? IBUS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any state change is a fresh grant (or a release); otherwise count the ack-less cycle
    assign cnt_clr = (state_d != state_q) || (state_q == IDLE);
    assign cnt_inc = ~cnt_clr;

    t5_wbarb_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .clr     (cnt_clr),
        .cnt     (cnt_inc),
        .expired (expired)
    );

    // Slave-side mux and ack steering from the granted master
    always_comb begin
        req_m   = '0;
        mwb_stb = 1'b0;
        mwb_dto = '0;
        iwb_ack = 1'b0;
        dwb_ack = 1'b0;
        case (state_q)
            IBUS: begin
                req_m   = '{adr: iwb_adr, wre: iwb_wre, sel: iwb_sel};
                mwb_stb = iwb_stb & ~tmo_hit;
                iwb_ack = ack_c | tmo_hit;
            end
            DBUS: begin
                req_m   = '{adr: dwb_adr, wre: dwb_wre, sel: dwb_sel};
                mwb_stb = dwb_stb & ~tmo_hit;
                mwb_dto = dwb_dto;
                dwb_ack = ack_c | tmo_hit;
            end
            default: ;
        endcase
    end

    assign mwb_adr = req_m.adr;
    assign mwb_wre = req_m.wre;
    assign mwb_sel = req_m.sel;

    assign iwb_dat = tmo_hit ? '0 : mwb_dti;
    assign dwb_dti = tmo_hit ? '0 : mwb_dti;
    assign gnt     = state_q;
    assign tmo_err = tmo_hit;

endmodule

// File: tb/tb_t5_wbarb.sv
// Self-checking bench for t5_wbarb: vector table for single transfers, hand-written
// sequences for arbitration, abort, timeout and reset; acks checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_t5_wbarb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TMO  = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [31:2]     iwb_adr;
    logic            iwb_stb;
    logic            iwb_wre;
    logic [3:0]      iwb_sel;
    logic [XLEN-1:0] iwb_dat;
    logic            iwb_ack;
    logic [31:2]     dwb_adr;
    logic            dwb_stb;
    logic            dwb_wre;
    logic [3:0]      dwb_sel;
    logic [XLEN-1:0] dwb_dto;
    logic [XLEN-1:0] dwb_dti;
    logic            dwb_ack;
    logic [31:2]     mwb_adr;
    logic            mwb_stb;
    logic            mwb_wre;
    logic [3:0]      mwb_sel;
    logic [XLEN-1:0] mwb_dto;
    logic [XLEN-1:0] mwb_dti;
    logic            mwb_ack;
    logic [1:0]      gnt;
    logic            tmo_err;

    t5_wbarb #(.XLEN(XLEN), .TMO(TMO)) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst),
        .iwb_adr (iwb_adr), .iwb_stb (iwb_stb), .iwb_wre (iwb_wre), .iwb_sel (iwb_sel),
        .iwb_dat (iwb_dat), .iwb_ack (iwb_ack),
        .dwb_adr (dwb_adr), .dwb_stb (dwb_stb), .dwb_wre (dwb_wre), .dwb_sel (dwb_sel),
        .dwb_dto (dwb_dto), .dwb_dti (dwb_dti), .dwb_ack (dwb_ack),
        .mwb_adr (mwb_adr), .mwb_stb (mwb_stb), .mwb_wre (mwb_wre), .mwb_sel (mwb_sel),
        .mwb_dto (mwb_dto), .mwb_dti (mwb_dti), .mwb_ack (mwb_ack),
        .gnt     (gnt),     .tmo_err (tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        is_d;
        logic [31:0] byte_adr;
        logic        wre;
        logic [3:0]  sel;
        logic [31:0] dto;
        logic [31:0] dti;
        int          wait_n;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_dto;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] dat;
        logic        tmo;
    } ack_t;

    vec_t vecs[5];
    ack_t sb_q[$];
    int   n_chk;
    int   n_err;
    bit   exp_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pop and compare an expected ack whenever either master sees one
    task automatic sb_sample();
        ack_t e;
        if (iwb_ack || dwb_ack) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ack: iwb_ack=%0b dwb_ack=%0b, expected none (t=%0t)",
                         iwb_ack, dwb_ack, $time);
            end else begin
                e = sb_q.pop_front();
                chk("ack_to_data", 64'(dwb_ack), 64'(e.is_d));
                chk("ack_to_inst", 64'(iwb_ack), 64'(!e.is_d));
                chk("ack_rdata", 64'(e.is_d ? dwb_dti : iwb_dat), 64'(e.dat));
                chk("ack_tmo_err", 64'(tmo_err), 64'(e.tmo));
            end
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
        sb_sample();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_in();
        iwb_adr = '0; iwb_stb = 1'b0; iwb_wre = 1'b0; iwb_sel = '0;
        dwb_adr = '0; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = '0; dwb_dto = '0;
        mwb_dti = '0; mwb_ack = 1'b0;
    endtask

    task automatic push_ack(input logic is_d, input logic [31:0] dat, input logic tmo);
        ack_t e;
        e.is_d = is_d;
        e.dat  = dat;
        e.tmo  = tmo;
        sb_q.push_back(e);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        vecs[0] = '{1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h1111_1111, 32'hCAFE_0001, 2, 2'b01, 32'h0};
        vecs[1] = '{1'b1, 32'h2000_0040, 1'b1, 4'h3, 32'hA5A5_5A5A, 32'h0000_0000, 0, 2'b10, 32'hA5A5_5A5A};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 4'h8, 32'h1234_5678, 32'h8765_4321, 1, 2'b10, 32'h1234_5678};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 4'h1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 2'b01, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, 32'h0BAD_F00D, 0, 2'b01, 32'h0};

        // Reset state
        idle_in();
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'(2'b00));
        chk("rst_mwb_stb", 64'(mwb_stb), 64'h0);
        chk("rst_mwb_adr", 64'(mwb_adr), 64'h0);
        chk("rst_iwb_ack", 64'(iwb_ack), 64'h0);
        chk("rst_dwb_ack", 64'(dwb_ack), 64'h0);
        chk("rst_tmo_err", 64'(tmo_err), 64'h0);
        sys_rst = 1'b1;
        cyc();

        // Single transfers from the vector table
        for (int v = 0; v < 5; v++) begin
            dwb_dto = vecs[v].dto;
            if (vecs[v].is_d) begin
                dwb_adr = 30'(vecs[v].byte_adr >> 2);
                dwb_wre = vecs[v].wre;
                dwb_sel = vecs[v].sel;
                dwb_stb = 1'b1;
            end else begin
                iwb_adr = 30'(vecs[v].byte_adr >> 2);
                iwb_wre = vecs[v].wre;
                iwb_sel = vecs[v].sel;
                iwb_stb = 1'b1;
            end
            mwb_dti = vecs[v].dti;
            #1;
            chk("vec_req_gnt", 64'(gnt), 64'(2'b00));
            chk("vec_req_mwb_stb", 64'(mwb_stb), 64'h0);
            cyc();
            chk("vec_gnt", 64'(gnt), 64'(vecs[v].exp_gnt));
            chk("vec_mwb_stb", 64'(mwb_stb), 64'h1);
            chk("vec_mwb_adr", 64'(mwb_adr), 64'(vecs[v].byte_adr >> 2));
            chk("vec_mwb_wre", 64'(mwb_wre), 64'(vecs[v].wre));
            chk("vec_mwb_sel", 64'(mwb_sel), 64'(vecs[v].sel));
            chk("vec_mwb_dto", 64'(mwb_dto), 64'(vecs[v].exp_dto));
            repeat (vecs[v].wait_n) cyc();
            chk("vec_gnt_hold", 64'(gnt), 64'(vecs[v].exp_gnt));
            mwb_ack = 1'b1;
            push_ack(vecs[v].is_d, vecs[v].dti, 1'b0);
            cyc();
            idle_in();
            #1;
            chk("vec_release_gnt", 64'(gnt), 64'(2'b00));
            cyc();
        end

        // Data master drops strobe before ack: abort, late ack discarded
        dwb_adr = 30'h123; dwb_stb = 1'b1;
        cyc();
        chk("abort_gnt", 64'(gnt), 64'(2'b10));
        dwb_stb = 1'b0;
        #1;
        chk("abort_mwb_stb", 64'(mwb_stb), 64'h0);
        cyc();
        chk("abort_idle", 64'(gnt), 64'(2'b00));
        mwb_ack = 1'b1;
        #1;
        chk("abort_late_dwb_ack", 64'(dwb_ack), 64'h0);
        chk("abort_late_iwb_ack", 64'(iwb_ack), 64'h0);
        cyc();
        idle_in();
        cyc();

        // Timeout: slave never acks
        iwb_adr = 30'h040; iwb_stb = 1'b1; mwb_dti = 32'hDEAD_BEEF;
        push_ack(1'b0, 32'h0, 1'b1);
        repeat (3) cyc();
        chk("tmo_c3_gnt", 64'(gnt), 64'(2'b01));
        chk("tmo_c3_err", 64'(tmo_err), 64'h0);
        cyc();
        chk("tmo_c4_err", 64'(tmo_err), 64'h1);
        chk("tmo_c4_iwb_ack", 64'(iwb_ack), 64'h1);
        chk("tmo_c4_iwb_dat", 64'(iwb_dat), 64'h0);
        chk("tmo_c4_mwb_stb", 64'(mwb_stb), 64'h0);
        cyc();
        chk("tmo_c5_gnt", 64'(gnt), 64'(2'b00));
        chk("tmo_c5_err", 64'(tmo_err), 64'h0);
        idle_in();
        cyc();

        // Ack arriving in the timeout cycle is a normal ack
        dwb_adr = 30'h777; dwb_stb = 1'b1;
        repeat (4) cyc();
        mwb_ack = 1'b1; mwb_dti = 32'h600D_DA7A;
        push_ack(1'b1, 32'h600D_DA7A, 1'b0);
        #1;
        chk("tmoack_err", 64'(tmo_err), 64'h0);
        cyc();
        idle_in();
        #1;
        chk("tmoack_idle", 64'(gnt), 64'(2'b00));
        cyc();

        // Reset in the middle of a data transfer
        dwb_adr = 30'h0AA; dwb_stb = 1'b1; dwb_dto = 32'h1357_9BDF;
        cyc();
        chk("rstmid_gnt_before", 64'(gnt), 64'(2'b10));
        sys_rst = 1'b0;
        mwb_ack = 1'b1;
        #1;
        chk("rstmid_gnt", 64'(gnt), 64'(2'b00));
        chk("rstmid_mwb_stb", 64'(mwb_stb), 64'h0);
        chk("rstmid_mwb_adr", 64'(mwb_adr), 64'h0);
        chk("rstmid_mwb_dto", 64'(mwb_dto), 64'h0);
        chk("rstmid_dwb_ack", 64'(dwb_ack), 64'h0);
        cyc();
        idle_in();
        sys_rst = 1'b1;
        cyc();
        iwb_adr = 30'h3C0; iwb_stb = 1'b1; mwb_dti = 32'h0000_00A1;
        cyc();
        chk("rstmid_new_gnt", 64'(gnt), 64'(2'b01));
        chk("rstmid_new_adr", 64'(mwb_adr), 64'h3C0);
        mwb_ack = 1'b1;
        push_ack(1'b0, 32'h0000_00A1, 1'b0);
        cyc();
        idle_in();
        cyc();

        // Simultaneous requests: data first, then straight to inst on ack
        iwb_adr = 30'h011; iwb_stb = 1'b1;
        dwb_adr = 30'h022; dwb_stb = 1'b1; mwb_dti = 32'h0000_D001;
        cyc();
        chk("both_first_gnt", 64'(gnt), 64'(2'b10));
        chk("both_first_adr", 64'(mwb_adr), 64'h022);
        mwb_ack = 1'b1;
        push_ack(1'b1, 32'h0000_D001, 1'b0);
        cyc();
        dwb_stb = 1'b0; mwb_ack = 1'b0; mwb_dti = 32'h0000_1001;
        #1;
        chk("both_switch_gnt", 64'(gnt), 64'(2'b01));
        chk("both_switch_adr", 64'(mwb_adr), 64'h011);
        chk("both_switch_stb", 64'(mwb_stb), 64'h1);
        mwb_ack = 1'b1;
        push_ack(1'b0, 32'h0000_1001, 1'b0);
        cyc();
        idle_in();
        #1;
        chk("both_done_gnt", 64'(gnt), 64'(2'b00));
        cyc();

        // Repeated simultaneous requests; loser withdraws when the winner is acked
        for (int r = 0; r < 4; r++) begin
`ifdef T5_WBARB_RR_EN
            exp_d = ((r % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            iwb_adr = 30'(32'h100 + r); iwb_stb = 1'b1;
            dwb_adr = 30'(32'h200 + r); dwb_stb = 1'b1;
            mwb_dti = 32'h5000_0000 + 32'(r);
            cyc();
            chk("round_gnt", 64'(gnt), exp_d ? 64'h2 : 64'h1);
            chk("round_adr", 64'(mwb_adr), exp_d ? 64'(32'h200 + r) : 64'(32'h100 + r));
            if (exp_d) iwb_stb = 1'b0;
            else       dwb_stb = 1'b0;
            mwb_ack = 1'b1;
            push_ack(exp_d, 32'h5000_0000 + 32'(r), 1'b0);
            cyc();
            idle_in();
            #1;
            chk("round_idle", 64'(gnt), 64'(2'b00));
            cyc();
        end

        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
